dbus_timer: RTL

DBUS_TIMER -- requirements
Module: dbus_timer

---
 rtl/dbus_timer_pkg.sv | 20 ++
 rtl/timer_counter.sv | 44 ++++
 rtl/dbus_timer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dbus_timer_pkg.sv
// rtl/dbus_timer_pkg.sv - register map and bit positions shared by the timer, bus decoder and software headers
package dbus_timer_pkg;

    localparam int WINDOW_BYTES = 32;
    localparam int WINDOW_LSB   = $clog2(WINDOW_BYTES);

    localparam logic [2:0] OFS_MTIME_LO = 3'd0;
    localparam logic [2:0] OFS_MTIME_HI = 3'd1;
    localparam logic [2:0] OFS_CMP_LO   = 3'd2;
    localparam logic [2:0] OFS_CMP_HI   = 3'd3;
    localparam logic [2:0] OFS_CTRL     = 3'd4;
    localparam logic [2:0] OFS_STATUS   = 3'd5;
    localparam logic [2:0] OFS_PRESCALE = 3'd6;
    localparam logic [2:0] OFS_RSVD     = 3'd7;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IE_BIT     = 1;
    localparam int STATUS_PEND_BIT = 0;

endpackage

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - 64-bit mtime counter advanced by a 16-bit prescaler
module timer_counter
    import dbus_timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] prescale,
    input  logic        cnt_clr,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] mtime
);

    logic [15:0] pre_cnt;
    logic        tick;

    assign tick = en && (pre_cnt == prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= 16'd0;
        end else if (cnt_clr) begin
            pre_cnt <= 16'd0;
        end else if (en) begin
            pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
        end
    end

    // A software write to either half wins over a coincident tick; the tick is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime <= 64'd0;
        end else if (wr_lo) begin
            mtime[31:0] <= wdata;
        end else if (wr_hi) begin
            mtime[63:32] <= wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: rtl/dbus_timer.sv
// rtl/dbus_timer.sv - memory-mapped 64-bit timer with compare interrupt on the core data bus
module dbus_timer
    import dbus_timer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter logic [15:0] PRESCALE_RST = 16'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] dbus_addr,
    input  logic [31:0] dbus_write,
    input  logic        dbus_wen,
    input  logic        dbus_ren,
    output logic [31:0] dbus_read,
    output logic        dbus_hit,
    output logic        interrupt
);

    logic        hit;
    logic [2:0]  ofs;
    logic        wr;
    logic [63:0] mtime;
    logic [63:0] cmp;
    logic [31:0] shadow;
    logic [15:0] prescale;
    logic        ctrl_en;
    logic        ctrl_ie;
    logic        pend;
    logic        irq_src;
    logic        irq_prev;
    logic [31:0] rdata;
    logic        unused_inputs;

    assign unused_inputs = ^{dbus_ren, dbus_addr[1:0]};

    assign hit     = (dbus_addr[15:WINDOW_LSB] == BASE_ADDR[15:WINDOW_LSB]);
    assign ofs     = dbus_addr[4:2];
    assign wr      = dbus_wen && hit;
    assign irq_src = pend && ctrl_ie;

    timer_counter u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (ctrl_en),
        .prescale (prescale),
        .cnt_clr  (wr && (ofs == OFS_CTRL || ofs == OFS_PRESCALE)),
        .wr_lo    (wr && ofs == OFS_MTIME_LO),
        .wr_hi    (wr && ofs == OFS_MTIME_HI),
        .wdata    (dbus_write),
        .mtime    (mtime)
    );

    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            case (ofs)
                OFS_MTIME_LO: rdata = mtime[31:0];
                OFS_MTIME_HI: rdata = shadow;
                OFS_CMP_LO:   rdata = cmp[31:0];
                OFS_CMP_HI:   rdata = cmp[63:32];
                OFS_CTRL: begin
                    rdata[CTRL_EN_BIT] = ctrl_en;
                    rdata[CTRL_IE_BIT] = ctrl_ie;
                end
                OFS_STATUS:   rdata[STATUS_PEND_BIT] = pend;
                OFS_PRESCALE: rdata[15:0] = prescale;
                OFS_RSVD:     rdata = 32'd0;
                default:      rdata = 32'd0;
            endcase
        end
    end

    // Reading MTIME_LO snapshots the high half so a LO-then-HI pair is never torn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbus_read <= 32'd0;
            dbus_hit  <= 1'b0;
            shadow    <= 32'd0;
        end else begin
            dbus_read <= rdata;
            dbus_hit  <= hit;
            if (hit && ofs == OFS_MTIME_LO) begin
                shadow <= mtime[63:32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp      <= 64'hFFFF_FFFF_FFFF_FFFF;
            ctrl_en  <= 1'b0;
            ctrl_ie  <= 1'b0;
            prescale <= PRESCALE_RST;
        end else if (wr) begin
            case (ofs)
                OFS_CMP_LO: cmp[31:0]  <= dbus_write;
                OFS_CMP_HI: cmp[63:32] <= dbus_write;
                OFS_CTRL: begin
                    ctrl_en <= dbus_write[CTRL_EN_BIT];
                    ctrl_ie <= dbus_write[CTRL_IE_BIT];
                end
                OFS_PRESCALE: prescale <= dbus_write[15:0];
                default: ;
            endcase
        end
    end

    // A true compare outranks a same-cycle W1C so a still-expired deadline stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            irq_prev  <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            if (mtime >= cmp) begin
                pend <= 1'b1;
            end else if (wr && ofs == OFS_STATUS && dbus_write[STATUS_PEND_BIT]) begin
                pend <= 1'b0;
            end
            irq_prev  <= irq_src;
            interrupt <= irq_src && !irq_prev;
        end
    end

endmodule
